uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo_if.sv | 39 +++
 rtl/rx_byte_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receiver types, constants and divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int c_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Bit period in clk cycles; truncating division matches the line-rate spec.
  function automatic int calc_div(input int clkfreq, input int baud);
    return clkfreq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : io-side read path of the buffered UART receiver.
//               rx_status exists only when UART_RX_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic                uart0_rd;
  logic                uart0_valid;
  logic [c_BYTE_W-1:0] uart0_data;
`ifdef UART_RX_STATUS_EN
  logic [1:0]          rx_status;
`endif

  modport master (
    output uart0_rd,
    input  uart0_valid,
    input  uart0_data
`ifdef UART_RX_STATUS_EN
    , input rx_status
`endif
  );

  modport slave (
    input  uart0_rd,
    output uart0_valid,
    output uart0_data
`ifdef UART_RX_STATUS_EN
    , output rx_status
`endif
  );

endinterface

`default_nettype wire

// File: rtl/rx_byte_fifo.sv
// ============================================================================
// Module      : rx_byte_fifo
// Description : Synchronous-write FIFO with combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_wdata,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [c_DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling 8N1 UART receiver feeding a byte FIFO.
//               Define UART_RX_STATUS_EN for sticky {overrun, framing_err}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKFREQ    = 12000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  input  wire logic      rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int                 c_DIV     = calc_div(CLKFREQ, BAUD);
  localparam int                 c_CNT_W   = $clog2(c_DIV + 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(c_DIV);
  localparam logic [c_CNT_W-1:0] c_HALF_LD = c_CNT_W'(c_DIV / 2);

  logic [1:0]          r_sync;
  logic [1:0]          r_settle;
  logic                r_armed;
  logic                w_rx_s;
  rx_state_t           r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]          r_bit_idx, w_bit_idx_nxt;
  logic [c_BYTE_W-1:0] r_shift, w_shift_nxt;
  logic                w_expire;
  logic                w_push;
  logic                w_frame_err;
  logic                w_overrun;
  logic                w_fifo_empty;
  logic                w_fifo_full;

  assign w_rx_s   = r_sync[1];
  assign w_expire = (r_cnt == c_CNT_W'(1));

  // Start detection is held off until the line has been seen idle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= 2'b11;
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rx};
      r_settle <= {r_settle[0], 1'b1};
      r_armed  <= r_armed | (r_settle[1] & w_rx_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_cnt_nxt   = c_HALF_LD;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (!w_expire) begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end else if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt     = c_DIV_LD;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!w_expire) begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end else begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_cnt_nxt              = c_DIV_LD;
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!w_expire) begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end else if (w_rx_s) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  rx_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (c_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (bus.uart0_rd),
    .i_wdata (r_shift),
    .o_head  (bus.uart0_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign bus.uart0_valid = ~w_fifo_empty;
  assign w_overrun       = w_push & w_fifo_full & ~bus.uart0_rd;

`ifdef UART_RX_STATUS_EN
  logic [1:0] r_status;

  // A new event in the same cycle as a read-clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= 2'b00;
    end else begin
      r_status[1] <= w_overrun   | (r_status[1] & ~bus.uart0_rd);
      r_status[0] <= w_frame_err | (r_status[0] & ~bus.uart0_rd);
    end
  end

  assign bus.rx_status = r_status;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_overrun ^ w_frame_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo at DIV=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int c_BIT = 16;

  logic clk;
  logic reset;
  logic rx;
  int   n_vec;
  int   n_err;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .CLKFREQ    (16),
    .BAUD       (1),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start bit plus 8 data bits, LSB first; caller drives the stop bit.
  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    repeat (c_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (c_BIT) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b);
    rx = 1'b1;
    repeat (c_BIT) @(negedge clk);
  endtask

  // Samples the read path, then issues a one-cycle pop strobe.
  task automatic do_pop(output logic v, output logic [7:0] d);
    v = bus.uart0_valid;
    d = bus.uart0_data;
    bus.uart0_rd = 1'b1;
    @(negedge clk);
    bus.uart0_rd = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    bus.uart0_rd = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b0 || bus.uart0_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%h, expected valid=0 data=00", bus.uart0_valid, bus.uart0_data);
    end
`ifdef UART_RX_STATUS_EN
    n_vec++;
    if (bus.rx_status !== 2'b00) begin
      n_err++;
      $display("FAIL reset_status: got %b, expected 00", bus.rx_status);
    end
`endif
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single;
    logic v;
    logic [7:0] d;
    send_head(8'h55);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pre_stop: valid=%b, expected 0", bus.uart0_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b1 || bus.uart0_data !== 8'h55) begin
      n_err++;
      $display("FAIL single_post_stop: valid=%b data=%h, expected valid=1 data=55", bus.uart0_valid, bus.uart0_data);
    end
    repeat (5) @(negedge clk);
    do_pop(v, d);
    n_vec++;
    if (bus.uart0_valid !== 1'b0 || bus.uart0_data !== 8'h00) begin
      n_err++;
      $display("FAIL single_after_pop: valid=%b data=%h, expected valid=0 data=00", bus.uart0_valid, bus.uart0_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    logic v;
    logic [7:0] d;
    exp = '{8'hA3, 8'h0F, 8'hFF};
    for (int i = 0; i < 3; i++) send_byte(exp[i]);
    for (int i = 0; i < 3; i++) begin
      do_pop(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_pop%0d: valid=%b data=%h, expected valid=1 data=%h", i, v, d, exp[i]);
      end
    end
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: valid=%b, expected 0", bus.uart0_valid);
    end
  endtask

  task automatic test_overrun;
    logic v;
    logic [7:0] d;
    logic drained_ok;
    for (int i = 0; i <= 16; i++) send_byte(8'(i));
`ifdef UART_RX_STATUS_EN
    n_vec++;
    if (bus.rx_status !== 2'b10) begin
      n_err++;
      $display("FAIL overrun_flag: got %b, expected 10", bus.rx_status);
    end
`endif
    drained_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_pop(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        n_err++;
        drained_ok = 1'b0;
        $display("FAIL overrun_pop%0d: valid=%b data=%h, expected valid=1 data=%h", i, v, d, 8'(i));
      end
    end
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_dropped: valid=%b data=%h, expected empty", bus.uart0_valid, bus.uart0_data);
    end
    // Second pass: pop during the 17th stop-sample cycle keeps the byte.
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_head(8'h10);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    bus.uart0_rd = 1'b1;
    @(negedge clk);
    bus.uart0_rd = 1'b0;
    repeat (5) @(negedge clk);
`ifdef UART_RX_STATUS_EN
    n_vec++;
    if (bus.rx_status !== 2'b00) begin
      n_err++;
      $display("FAIL overrun_no_flag: got %b, expected 00", bus.rx_status);
    end
`endif
    for (int i = 1; i <= 16; i++) begin
      do_pop(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        n_err++;
        $display("FAIL retain_pop%0d: valid=%b data=%h, expected valid=1 data=%h", i, v, d, 8'(i));
      end
    end
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL retain_drain: valid=%b, expected 0", bus.uart0_valid);
    end
  endtask

  task automatic test_glitch;
    logic v;
    logic [7:0] d;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_no_byte: valid=%b, expected 0", bus.uart0_valid);
    end
    send_byte(8'h5A);
    do_pop(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== 8'h5A) begin
      n_err++;
      $display("FAIL glitch_recover: valid=%b data=%h, expected valid=1 data=5a", v, d);
    end
  endtask

  task automatic test_framing;
    logic v;
    logic [7:0] d;
    send_head(8'h81);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL framing_no_byte: valid=%b data=%h, expected valid=0", bus.uart0_valid, bus.uart0_data);
    end
`ifdef UART_RX_STATUS_EN
    n_vec++;
    if (bus.rx_status !== 2'b01) begin
      n_err++;
      $display("FAIL framing_flag: got %b, expected 01", bus.rx_status);
    end
`endif
    send_byte(8'h42);
    do_pop(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== 8'h42) begin
      n_err++;
      $display("FAIL framing_recover: valid=%b data=%h, expected valid=1 data=42", v, d);
    end
`ifdef UART_RX_STATUS_EN
    n_vec++;
    if (bus.rx_status !== 2'b00) begin
      n_err++;
      $display("FAIL framing_clear: got %b, expected 00", bus.rx_status);
    end
`endif
  endtask

  task automatic test_reset_mid_byte;
    logic v;
    logic [7:0] d;
    send_byte(8'h11);
    send_byte(8'h22);
    rx = 1'b0;
    repeat (c_BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      repeat (c_BIT) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.uart0_valid !== 1'b0 || bus.uart0_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_byte: valid=%b data=%h, expected valid=0 data=00", bus.uart0_valid, bus.uart0_data);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: valid=%b, expected 0", bus.uart0_valid);
    end
    send_byte(8'h99);
    do_pop(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== 8'h99) begin
      n_err++;
      $display("FAIL reset_recover: valid=%b data=%h, expected valid=1 data=99", v, d);
    end
    n_vec++;
    if (bus.uart0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drain: valid=%b, expected 0", bus.uart0_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_framing();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
